rgb888_to_ycbcr: RTL and testbench
==================================

Name: rgb888_to_ycbcr

Overview:
- Upstream neighbour of the Y-channel Sobel enhancement stage: converts the camera's RGB888 pixel stream to BT.601 full-range YCbCr. Y feeds the enhancement path; Cb/Cr are kept for later recombination.
- Pipelined at 3 clk latency; vsync/href/clken are delayed to stay aligned with the data.
- Also emits the aligned pixel column/row coordinates so downstream stages need no counters of their own.

Parameters:
- IMG_HDISP, 640, active pixels per line; width of post_x range.
- IMG_VDISP, 480, active lines per frame; width of post_y range.
- PIPE_LAT, 3, pipeline latency in clk; fixed, exported for benches, not overridable in RTL.

Ports:
- clk  in  1  pixel clock, all logic on rising edge.
- rst  in  1  synchronous, active-high reset.
- per_frame_vsync  in  1  frame valid (H: valid, L: sync/invalid).
- per_frame_href  in  1  line valid.
- per_frame_clken  in  1  pixel enable.
- per_img_red  in  8  R component.
- per_img_green  in  8  G component.
- per_img_blue  in  8  B component.
- post_frame_vsync  out  1  per_frame_vsync delayed PIPE_LAT.
- post_frame_href  out  1  per_frame_href delayed PIPE_LAT.
- post_frame_clken  out  1  per_frame_clken delayed PIPE_LAT.
- post_img_Y  out  8  luma.
- post_img_Cb  out  8  blue-difference chroma.
- post_img_Cr  out  8  red-difference chroma.
- post_x  out  11  column of current output pixel.
- post_y  out  11  row of current output line.

Behaviour:
- Reset (rst=1 at a clk edge): all pipeline registers, delayed syncs, outputs and counters go to 0. Mid-frame reset discards all in-flight pixels; there is no partial-frame recovery. The first valid output follows the next vsync rise.
- Datapath is free-running: it advances every clk regardless of clken. Input is sampled every cycle, and out(t) = f(in(t-3)).
- Stage 1: nine 8x8 unsigned products using the constants R/G/B = Y:77,150,29; Cb:43,85,128; Cr:128,107,21.
- Stage 2, sums in 17-bit:
  - Y = 77R + 150G + 29B
  - Cb = 128B - 43R - 85G + 32768
  - Cr = 128R - 107G - 21B + 32768
  - Subtractions are arranged so no intermediate goes negative: add 32768 first.
- Stage 3: output = sum[15:8]. This is truncation with no rounding. The range provably stays in 0..65408, so no clamp logic is required, but the register must still take bits [15:8] only.
- Sync delay: vsync, href and clken each pass through a 3-deep shift register and are never gated by data.
- post_x (counts on the delayed signals):
  - 0 while post_frame_href=0.
  - Increments after each cycle with post_frame_href=1 and post_frame_clken=1.
  - Saturates at IMG_HDISP-1; it does not wrap.
- post_y:
  - 0 while post_frame_vsync=0.
  - Increments on each falling edge of post_frame_href.
  - Saturates at IMG_VDISP-1.
- Simultaneous vsync fall and href fall: clear wins.
- A line longer than IMG_HDISP: data continues and post_x holds at max.

Optional Feature:
- Macro: YCBCR_CHROMA_EN.
- Defined: full Cb/Cr path as above.
- Undefined:
  - The six chroma multipliers and both chroma adders are not instantiated.
  - post_img_Cb and post_img_Cr are driven constant 8'd128 (neutral chroma) and are unaffected by reset.
  - Y, syncs and counters are unchanged.

Decomposition:
- Package ycbcr_pkg: the nine coefficient constants, the chroma offset 32768, PIPE_LAT=3, and the neutral chroma value 128.
- One sub-module: sync_delay, a parameterised-depth shift register for vsync/href/clken with synchronous active-high reset. It is reused by the Sobel stage for its own alignment.

Test Plan:
- White (255,255,255) -> Y=255, Cb=128, Cr=128, appearing exactly 3 clk after input.
- Black (0,0,0) -> Y=0, Cb=128, Cr=128.
- Red (255,0,0) -> Y=76, Cb=85, Cr=255.
- Blue (0,0,255) -> Y=28, Cb=255, Cr=107.
- Bench 2-line 640-pixel frame with alternating clken:
  - post_x steps 0..639 on clken cycles and holds at 639 if the line is over-length.
  - post_y goes 0 to 1 on the first href fall.
  - Syncs match the inputs shifted 3 clk.
- rst pulsed for 1 clk mid-line -> next cycle all outputs and counters are 0, including in-flight pixels.
- Build without YCBCR_CHROMA_EN -> Cb=Cr=128 for all of the above stimuli, with Y values unchanged.

Source files
------------

// File: rtl/ycbcr_pkg.sv
// ycbcr_pkg: shared constants and types for the RGB888 to YCbCr stage.
// BT.601 full-range coefficients scaled by 256.
package ycbcr_pkg;

  localparam int PIPE_LAT = 3;

  localparam logic [7:0] K_YR  = 8'd77;
  localparam logic [7:0] K_YG  = 8'd150;
  localparam logic [7:0] K_YB  = 8'd29;
  localparam logic [7:0] K_CBR = 8'd43;
  localparam logic [7:0] K_CBG = 8'd85;
  localparam logic [7:0] K_CBB = 8'd128;
  localparam logic [7:0] K_CRR = 8'd128;
  localparam logic [7:0] K_CRG = 8'd107;
  localparam logic [7:0] K_CRB = 8'd21;

  localparam logic [16:0] C_OFS     = 17'd32768;
  localparam logic [7:0]  C_NEUTRAL = 8'd128;

  typedef struct packed {
    logic vsync;
    logic href;
    logic clken;
  } sync_t;

endpackage

// File: rtl/sync_delay.sv
// sync_delay: parameterised shift register for frame sync alignment.
// Exposes every tap so callers can look one stage ahead of the output.
module sync_delay #(
  parameter int W     = 3,
  parameter int DEPTH = 3
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic [W-1:0]              d,
  output logic [DEPTH-1:0][W-1:0]   taps
);

  always_ff @(posedge clk) begin
    if (rst) begin
      taps <= '0;
    end else begin
      taps[0] <= d;
      for (int i = 1; i < DEPTH; i++) begin
        taps[i] <= taps[i-1];
      end
    end
  end

endmodule

// File: rtl/rgb888_to_ycbcr.sv
// rgb888_to_ycbcr: RGB888 -> BT.601 full-range YCbCr, 3-clk pipeline.
// Define YCBCR_CHROMA_EN for the Cb/Cr path; otherwise chroma is 128.
module rgb888_to_ycbcr
  import ycbcr_pkg::*;
#(
  parameter int IMG_HDISP = 640,
  parameter int IMG_VDISP = 480
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        per_frame_vsync,
  input  logic        per_frame_href,
  input  logic        per_frame_clken,
  input  logic [7:0]  per_img_red,
  input  logic [7:0]  per_img_green,
  input  logic [7:0]  per_img_blue,
  output logic        post_frame_vsync,
  output logic        post_frame_href,
  output logic        post_frame_clken,
  output logic [7:0]  post_img_Y,
  output logic [7:0]  post_img_Cb,
  output logic [7:0]  post_img_Cr,
  output logic [10:0] post_x,
  output logic [10:0] post_y
);

  localparam logic [10:0] X_MAX = 11'(IMG_HDISP - 1);
  localparam logic [10:0] Y_MAX = 11'(IMG_VDISP - 1);

  logic [15:0] p_yr, p_yg, p_yb;
  logic [16:0] s_y;

  always_ff @(posedge clk) begin
    if (rst) begin
      p_yr       <= '0;
      p_yg       <= '0;
      p_yb       <= '0;
      s_y        <= '0;
      post_img_Y <= '0;
    end else begin
      p_yr       <= 16'(per_img_red)   * 16'(K_YR);
      p_yg       <= 16'(per_img_green) * 16'(K_YG);
      p_yb       <= 16'(per_img_blue)  * 16'(K_YB);
      s_y        <= 17'(p_yr) + 17'(p_yg) + 17'(p_yb);
      post_img_Y <= s_y[15:8];
    end
  end

`ifdef YCBCR_CHROMA_EN
  logic [15:0] p_cbr, p_cbg, p_cbb;
  logic [15:0] p_crr, p_crg, p_crb;
  logic [16:0] s_cb, s_cr;

  // Offset added before subtracting keeps every partial sum non-negative.
  always_ff @(posedge clk) begin
    if (rst) begin
      p_cbr       <= '0;
      p_cbg       <= '0;
      p_cbb       <= '0;
      p_crr       <= '0;
      p_crg       <= '0;
      p_crb       <= '0;
      s_cb        <= '0;
      s_cr        <= '0;
      post_img_Cb <= '0;
      post_img_Cr <= '0;
    end else begin
      p_cbr       <= 16'(per_img_red)   * 16'(K_CBR);
      p_cbg       <= 16'(per_img_green) * 16'(K_CBG);
      p_cbb       <= 16'(per_img_blue)  * 16'(K_CBB);
      p_crr       <= 16'(per_img_red)   * 16'(K_CRR);
      p_crg       <= 16'(per_img_green) * 16'(K_CRG);
      p_crb       <= 16'(per_img_blue)  * 16'(K_CRB);
      s_cb        <= 17'(p_cbb) + C_OFS
                   - 17'(p_cbr) - 17'(p_cbg);
      s_cr        <= 17'(p_crr) + C_OFS
                   - 17'(p_crg) - 17'(p_crb);
      post_img_Cb <= s_cb[15:8];
      post_img_Cr <= s_cr[15:8];
    end
  end

  logic unused_chroma;
  assign unused_chroma = ^{s_cb[16], s_cb[7:0],
                           s_cr[16], s_cr[7:0]};
`else
  assign post_img_Cb = C_NEUTRAL;
  assign post_img_Cr = C_NEUTRAL;
`endif

  logic [PIPE_LAT-1:0][2:0] taps;
  sync_t in_sync, cur, nxt;

  assign in_sync = '{vsync: per_frame_vsync,
                     href:  per_frame_href,
                     clken: per_frame_clken};

  sync_delay #(
    .W     (3),
    .DEPTH (PIPE_LAT)
  ) u_sync (
    .clk  (clk),
    .rst  (rst),
    .d    (in_sync),
    .taps (taps)
  );

  assign cur = taps[PIPE_LAT-1];
  assign nxt = taps[PIPE_LAT-2];

  assign post_frame_vsync = cur.vsync;
  assign post_frame_href  = cur.href;
  assign post_frame_clken = cur.clken;

  // Counters look one tap ahead so they clear in step with the syncs.
  always_ff @(posedge clk) begin
    if (rst) begin
      post_x <= '0;
    end else if (!nxt.href) begin
      post_x <= '0;
    end else if (cur.href && cur.clken && post_x < X_MAX) begin
      post_x <= post_x + 11'd1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      post_y <= '0;
    end else if (!nxt.vsync) begin
      post_y <= '0;
    end else if (cur.href && !nxt.href && post_y < Y_MAX) begin
      post_y <= post_y + 11'd1;
    end
  end

  logic unused_bits;
  assign unused_bits = ^{s_y[16], s_y[7:0], taps[0]};

endmodule

// File: tb/tb_rgb888_to_ycbcr.sv
// tb_rgb888_to_ycbcr: scoreboard bench for rgb888_to_ycbcr.
// Directed pixels, 2-line frame with over-length line, mid-line reset.
module tb_rgb888_to_ycbcr;
  import ycbcr_pkg::*;

  localparam int HD = 640;
  localparam int VD = 480;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        per_frame_vsync = 1'b0;
  logic        per_frame_href = 1'b0;
  logic        per_frame_clken = 1'b0;
  logic [7:0]  per_img_red = '0;
  logic [7:0]  per_img_green = '0;
  logic [7:0]  per_img_blue = '0;
  logic        post_frame_vsync;
  logic        post_frame_href;
  logic        post_frame_clken;
  logic [7:0]  post_img_Y;
  logic [7:0]  post_img_Cb;
  logic [7:0]  post_img_Cr;
  logic [10:0] post_x;
  logic [10:0] post_y;

  rgb888_to_ycbcr #(
    .IMG_HDISP (HD),
    .IMG_VDISP (VD)
  ) dut (
    .clk              (clk),
    .rst              (rst),
    .per_frame_vsync  (per_frame_vsync),
    .per_frame_href   (per_frame_href),
    .per_frame_clken  (per_frame_clken),
    .per_img_red      (per_img_red),
    .per_img_green    (per_img_green),
    .per_img_blue     (per_img_blue),
    .post_frame_vsync (post_frame_vsync),
    .post_frame_href  (post_frame_href),
    .post_frame_clken (post_frame_clken),
    .post_img_Y       (post_img_Y),
    .post_img_Cb      (post_img_Cb),
    .post_img_Cr      (post_img_Cr),
    .post_x           (post_x),
    .post_y           (post_y)
  );

  always #5 clk = ~clk;

  // white, black, red, blue, green, gray, (100,50,200)
  logic [7:0] vr [7] = '{255, 0, 255, 0, 0, 128, 100};
  logic [7:0] vg [7] = '{255, 0, 0, 0, 255, 128, 50};
  logic [7:0] vb [7] = '{255, 0, 0, 255, 0, 128, 200};
  logic [7:0] ey [7] = '{255, 0, 76, 28, 149, 128, 82};
`ifdef YCBCR_CHROMA_EN
  logic [7:0] ecb [7] = '{128, 128, 85, 255, 43, 128, 194};
  logic [7:0] ecr [7] = '{128, 128, 255, 107, 21, 128, 140};
  localparam logic [7:0] RST_C = 8'd0;
`else
  logic [7:0] ecb [7] = '{128, 128, 128, 128, 128, 128, 128};
  logic [7:0] ecr [7] = '{128, 128, 128, 128, 128, 128, 128};
  localparam logic [7:0] RST_C = 8'd128;
`endif

  typedef struct {
    logic [7:0]  y;
    logic [7:0]  cb;
    logic [7:0]  cr;
    logic [10:0] x;
    logic [10:0] row;
  } exp_t;

  exp_t sb [$];
  int   n_cmp = 0;
  int   n_bad = 0;
  int   xcnt = 0;
  int   ycnt = 0;
  logic prev_h = 1'b0;
  logic go = 1'b0;
  logic [2:0] hist [3] = '{3'b0, 3'b0, 3'b0};

  always @(posedge clk) begin
    if (rst) begin
      hist = '{3'b0, 3'b0, 3'b0};
    end else begin
      hist[2] = hist[1];
      hist[1] = hist[0];
      hist[0] = {per_frame_vsync, per_frame_href,
                 per_frame_clken};
    end
  end

  always @(negedge clk) begin
    exp_t e;
    if (go) begin
      n_cmp++;
      if ({post_frame_vsync, post_frame_href,
           post_frame_clken} !== hist[2]) begin
        n_bad++;
        $display("FAIL sync_delay: got %b want %b at %0t",
                 {post_frame_vsync, post_frame_href,
                  post_frame_clken}, hist[2], $time);
      end
      if (!post_frame_href || !post_frame_vsync) begin
        n_cmp++;
        if ((!post_frame_href && post_x !== 11'd0) ||
            (!post_frame_vsync && post_y !== 11'd0)) begin
          n_bad++;
          $display("FAIL cnt_clear: got x=%0d y=%0d want 0 at %0t",
                   post_x, post_y, $time);
        end
      end
      if (post_frame_clken) begin
        n_cmp++;
        if (sb.size() == 0) begin
          n_bad++;
          $display("FAIL unexpected_pixel: got clken=1 want none at %0t",
                   $time);
        end else begin
          e = sb.pop_front();
          if (post_img_Y !== e.y || post_img_Cb !== e.cb ||
              post_img_Cr !== e.cr || post_x !== e.x ||
              post_y !== e.row) begin
            n_bad++;
            $display({"FAIL pixel: got Y=%0d Cb=%0d Cr=%0d x=%0d y=%0d",
                      " want Y=%0d Cb=%0d Cr=%0d x=%0d y=%0d at %0t"},
                     post_img_Y, post_img_Cb, post_img_Cr, post_x,
                     post_y, e.y, e.cb, e.cr, e.x, e.row, $time);
          end
        end
      end
    end
  end

  task automatic step(input logic v, input logic h,
                      input logic c, input int vi);
    exp_t e;
    @(negedge clk);
    if (!v) ycnt = 0;
    else if (prev_h && !h && ycnt < VD - 1) ycnt++;
    if (!h) xcnt = 0;
    per_frame_vsync = v;
    per_frame_href  = h;
    per_frame_clken = c;
    per_img_red     = vr[vi];
    per_img_green   = vg[vi];
    per_img_blue    = vb[vi];
    if (c) begin
      e.y   = ey[vi];
      e.cb  = ecb[vi];
      e.cr  = ecr[vi];
      e.x   = h ? 11'(xcnt) : 11'd0;
      e.row = v ? 11'(ycnt) : 11'd0;
      sb.push_back(e);
    end
    if (h && c && xcnt < HD - 1) xcnt++;
    prev_h = h;
  endtask

  task automatic check_zero(input string tag);
    n_cmp++;
    if (post_img_Y !== 8'd0 || post_img_Cb !== RST_C ||
        post_img_Cr !== RST_C) begin
      n_bad++;
      $display("FAIL %s_data: got Y=%0d Cb=%0d Cr=%0d want 0,%0d,%0d",
               tag, post_img_Y, post_img_Cb, post_img_Cr, RST_C, RST_C);
    end
    n_cmp++;
    if ({post_frame_vsync, post_frame_href,
         post_frame_clken} !== 3'b000) begin
      n_bad++;
      $display("FAIL %s_sync: got %b want 000", tag,
               {post_frame_vsync, post_frame_href, post_frame_clken});
    end
    n_cmp++;
    if (post_x !== 11'd0 || post_y !== 11'd0) begin
      n_bad++;
      $display("FAIL %s_cnt: got x=%0d y=%0d want 0,0",
               tag, post_x, post_y);
    end
  endtask

  task automatic mid_reset();
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    per_frame_clken = 1'b0;
    sb.delete();
    xcnt = 0;
    ycnt = 0;
    check_zero("mid_reset");
  endtask

  initial begin
    repeat (3) @(negedge clk);
    rst = 1'b0;
    check_zero("reset");
    go = 1'b1;

    for (int i = 0; i < 7; i++) step(1'b0, 1'b0, 1'b1, i);
    for (int i = 0; i < 7; i++) begin
      step(1'b0, 1'b0, 1'b1, i);
      step(1'b0, 1'b0, 1'b0, 0);
    end

    repeat (3) step(1'b0, 1'b0, 1'b0, 0);
    repeat (4) step(1'b1, 1'b0, 1'b0, 0);
    for (int i = 0; i < 1290; i++)
      step(1'b1, 1'b1, (i % 2) == 0, (i / 2) % 7);
    repeat (10) step(1'b1, 1'b0, 1'b0, 0);
    for (int i = 0; i < 1280; i++)
      step(1'b1, 1'b1, (i % 2) == 1, (i / 2) % 7);
    repeat (10) step(1'b1, 1'b0, 1'b0, 0);
    repeat (5) step(1'b0, 1'b0, 1'b0, 0);

    repeat (4) step(1'b1, 1'b0, 1'b0, 0);
    for (int i = 0; i < 40; i++) step(1'b1, 1'b1, 1'b1, i % 7);
    repeat (6) step(1'b1, 1'b0, 1'b0, 0);
    for (int i = 0; i < 100; i++) step(1'b1, 1'b1, 1'b1, i % 7);
    mid_reset();
    for (int i = 0; i < 100; i++)
      step(1'b1, 1'b1, (i % 2) == 0, (i + 3) % 7);
    repeat (6) step(1'b1, 1'b0, 1'b0, 0);
    for (int i = 0; i < 30; i++) step(1'b1, 1'b1, 1'b1, i % 7);
    step(1'b0, 1'b0, 1'b0, 0);

    for (int i = 0; i < 20 && sb.size() != 0; i++)
      step(1'b0, 1'b0, 1'b0, 0);
    n_cmp++;
    if (sb.size() != 0) begin
      n_bad++;
      $display("FAIL drain: got %0d pending want 0", sb.size());
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***",
             n_cmp, n_bad);
    $finish;
  end

endmodule
